// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared scan-code constants, FSM state encoding and key-id helper for the PS/2 keyboard sequencer.
package ps2_kbd_ctrl_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StEmit   = 2'd2
    } state_e;

    // Held-key identity: extended flag above the base scan code.
    function automatic logic [8:0] key_id(input logic ext, input logic [7:0] code);
        return {ext, code};
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Pops scan-code bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes into key events and
// presents them on a valid/ready handshake while tracking the held key and a press counter.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 8,
    parameter bit          SUPPRESS_RPT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    input  logic             kbd_overflow,
    output logic             kbd_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_brk,
    output logic             held_valid,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             err
);

    state_e             state_q, state_d;
    logic [7:0]         byte_q;
    logic               ext_q, brk_q;
    logic               evt_valid_q, evt_ext_q, evt_brk_q;
    logic [7:0]         evt_code_q;
    logic               held_valid_q;
    logic [8:0]         held_code_q;
    logic [CNT_W-1:0]   press_cnt_q;
    logic               err_q;

    logic is_ext, is_brk, proto_err, is_repeat, accept;

    always_comb begin
        is_ext    = (byte_q == SC_EXT);
        is_brk    = (byte_q == SC_BRK);
        // A second prefix after F0 is malformed; the sequence is dropped.
        proto_err = brk_q && (is_ext || is_brk);
        is_repeat = SUPPRESS_RPT && !brk_q && held_valid_q
                    && (held_code_q == key_id(ext_q, byte_q));
        accept    = (state_q == StEmit) && evt_valid_q && evt_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (kbd_ready) state_d = StSettle;
            end
            StSettle: begin
                if (!is_ext && !is_brk && !is_repeat) state_d = StEmit;
                else                                  state_d = StIdle;
            end
            StEmit: begin
                if (accept) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe is combinational so it lasts exactly the capture cycle; reset forces it high at once.
    always_comb begin
        kbd_nextdata_n = !((state_q == StIdle) && kbd_ready && !rst);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q       <= 8'h00;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_ext_q    <= 1'b0;
            evt_brk_q    <= 1'b0;
            evt_code_q   <= 8'h00;
            held_valid_q <= 1'b0;
            held_code_q  <= 9'h000;
            press_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            if (kbd_overflow) err_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (kbd_ready) byte_q <= kbd_data;
                end
                StSettle: begin
                    if (proto_err) begin
                        err_q <= 1'b1;
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end else if (is_ext) begin
                        ext_q <= 1'b1;
                    end else if (is_brk) begin
                        brk_q <= 1'b1;
                    end else begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (!is_repeat) begin
                            evt_code_q  <= byte_q;
                            evt_ext_q   <= ext_q;
                            evt_brk_q   <= brk_q;
                            evt_valid_q <= 1'b1;
                        end
                    end
                end
                StEmit: begin
                    if (accept) begin
                        evt_valid_q <= 1'b0;
                        if (!evt_brk_q) begin
                            held_code_q  <= key_id(evt_ext_q, evt_code_q);
                            held_valid_q <= 1'b1;
                            press_cnt_q  <= press_cnt_q + CNT_W'(1);
                        end else if (held_valid_q
                                     && held_code_q == key_id(evt_ext_q, evt_code_q)) begin
                            held_valid_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_ext    = evt_ext_q;
    assign evt_brk    = evt_brk_q;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;
    assign press_cnt  = press_cnt_q;
    assign err        = err_q;

endmodule
